// File: rtl/scic_core.sv
// Simple accumulator computer: 3-cycle FETCH/DECODE/EXECUTE CPU with unified RAM
// and memory-mapped switch input / LED output.
module scic_core #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [15:0] SW_ADDR   = 16'hFFFE,
  parameter logic [15:0] LED_ADDR  = 16'hFFFF
) (
  output logic [15:0] PC,
  output logic [31:0] IR,
  output logic [31:0] AC,
  output logic [3:0]  LEDs,
  input  logic [3:0]  switches,
  input  logic        reset,
  input  logic        clock
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_LOAD  = 4'h2,
    OP_STORE = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_JUMP  = 4'h6,
    OP_JNEG  = 4'h7,
    OP_JZERO = 4'h8,
    OP_LOADI = 4'h9,
    OP_NOT   = 4'hA,
    OP_HALT  = 4'hF
  } op_e;

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] mdr;
  state_e      state;
  op_e         op;
  logic [15:0] addr;
  logic        mem_we_c;

  assign op   = op_e'(IR[31:28]);
  assign addr = IR[15:0];

  // Plain RAM write; I/O addresses never touch the array, reset suppresses the write.
  assign mem_we_c = !reset && (state == EXECUTE) && (op == OP_STORE) &&
                    (addr != LED_ADDR) && (addr != SW_ADDR);

  always_ff @(posedge clock) begin
    if (mem_we_c) mem[addr[AW-1:0]] <= AC;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      PC    <= 16'h0000;
      IR    <= 32'h0000_0000;
      AC    <= 32'h0000_0000;
      LEDs  <= 4'h0;
      mdr   <= 32'h0000_0000;
      state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          IR    <= mem[PC[AW-1:0]];
          PC    <= PC + 16'd1;
          state <= DECODE;
        end
        DECODE: begin
          mdr   <= (addr == SW_ADDR) ? {28'h0, switches} : mem[addr[AW-1:0]];
          state <= EXECUTE;
        end
        EXECUTE: begin
          state <= FETCH;
          case (op)
            OP_ADD:   AC <= AC + mdr;
            OP_SUB:   AC <= AC - mdr;
            OP_LOAD:  AC <= mdr;
            OP_STORE: if (addr == LED_ADDR) LEDs <= AC[3:0];
            OP_AND:   AC <= AC & mdr;
            OP_OR:    AC <= AC | mdr;
            OP_JUMP:  PC <= addr;
            OP_JNEG:  if (AC[31]) PC <= addr;
            OP_JZERO: if (AC == 32'h0000_0000) PC <= addr;
            OP_LOADI: AC <= {{16{addr[15]}}, addr};
            OP_NOT:   AC <= ~AC;
            OP_HALT:  state <= EXECUTE;
            default:  ;
          endcase
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_scic_core.sv
// Directed bench for scic_core: program preloaded into the core RAM, results checked
// against hand-computed register values at instruction boundaries.
module tb_scic_core;

  logic        clock;
  logic        reset;
  logic [3:0]  switches;
  logic [15:0] PC;
  logic [31:0] IR;
  logic [31:0] AC;
  logic [3:0]  LEDs;

  int vectors = 0;
  int errs    = 0;

  scic_core dut (
    .PC       (PC),
    .IR       (IR),
    .AC       (AC),
    .LEDs     (LEDs),
    .switches (switches),
    .reset    (reset),
    .clock    (clock)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    dut.mem[a] = d;
  endtask

  task automatic wait_leds(input logic [3:0] exp, input int limit);
    for (int i = 0; i < limit && LEDs !== exp; i++) step(1);
  endtask

  task automatic wait_pc(input logic [15:0] exp, input int limit);
    for (int i = 0; i < limit && PC !== exp; i++) step(1);
  endtask

  initial begin
    reset    = 1'b1;
    switches = 4'b0101;

    // Program image
    poke(8'h00, 32'h9000_0005);  // LOADI 5
    poke(8'h01, 32'h9000_7FFF);  // LOADI 0x7FFF
    poke(8'h02, 32'h0000_0010);  // ADD  [0x10]
    poke(8'h03, 32'h1000_0010);  // SUB  [0x10]
    poke(8'h04, 32'h9000_FFFF);  // LOADI -1
    poke(8'h05, 32'h8000_0030);  // JZERO 0x30 (not taken)
    poke(8'h06, 32'h7000_0020);  // JNEG 0x20 (taken)
    poke(8'h20, 32'h4000_0012);  // AND  [0x12]
    poke(8'h21, 32'h5000_0013);  // OR   [0x13]
    poke(8'h22, 32'hA000_0000);  // NOT
    poke(8'h23, 32'h3000_0011);  // STORE [0x11]
    poke(8'h24, 32'h9000_0000);  // LOADI 0
    poke(8'h25, 32'h2000_0011);  // LOAD [0x11]
    poke(8'h26, 32'h9000_0006);  // LOADI 6
    poke(8'h27, 32'h3000_FFFF);  // STORE LEDs
    poke(8'h28, 32'hB000_0000);  // no-op opcode
    poke(8'h29, 32'h3000_FFFE);  // STORE to switch address: no effect
    poke(8'h2A, 32'h2000_01FE);  // LOAD aliased 0x1FE -> mem[0xFE]
    poke(8'h2B, 32'h6000_0040);  // JUMP 0x40
    poke(8'h40, 32'h2000_FFFE);  // LOAD switches
    poke(8'h41, 32'h3000_FFFF);  // STORE LEDs
    poke(8'h42, 32'h1000_0014);  // SUB 15
    poke(8'h43, 32'h8000_0050);  // JZERO 0x50 when switches == 4'hF
    poke(8'h44, 32'h6000_0040);  // JUMP 0x40
    poke(8'h50, 32'h2000_FFFF);  // LOAD from LED address -> mem[0xFF]
    poke(8'h51, 32'h6000_FFFF);  // JUMP 0xFFFF
    poke(8'h10, 32'hFFFF_FFFF);
    poke(8'h12, 32'h0000_000F);
    poke(8'h13, 32'h0000_0030);
    poke(8'h14, 32'h0000_000F);
    poke(8'hFE, 32'h1234_5678);
    poke(8'hFF, 32'hF000_0000);  // HALT, also data for the LED-address load

    step(3);
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_ac", AC, 32'h0);
    chk("rst_leds", 32'(LEDs), 32'h0);
    reset = 1'b0;

    step(1);
    chk("fetch_ir", IR, 32'h9000_0005);
    chk("fetch_pc", 32'(PC), 32'h1);
    chk("fetch_ac", AC, 32'h0);
    step(2);
    chk("loadi5", AC, 32'h5);

    step(3); chk("loadi_7fff", AC, 32'h0000_7FFF);
    step(3); chk("add_wrap", AC, 32'h0000_7FFE);
    step(3); chk("sub_wrap", AC, 32'h0000_7FFF);
    step(3); chk("loadi_neg", AC, 32'hFFFF_FFFF);
    step(3); chk("jzero_nt", 32'(PC), 32'h6);
    step(3); chk("jneg_t", 32'(PC), 32'h20);
    step(3); chk("and", AC, 32'h0000_000F);
    step(3); chk("or", AC, 32'h0000_003F);
    step(3); chk("not", AC, 32'hFFFF_FFC0);
    step(3);
    step(3); chk("loadi0", AC, 32'h0);
    step(3); chk("load_stored", AC, 32'hFFFF_FFC0);
    step(3);
    step(3); chk("store_led", 32'(LEDs), 32'h6);
    step(3); chk("nop_ac", AC, 32'h6);
    chk("nop_pc", 32'(PC), 32'h29);
    step(3);
    step(3); chk("load_alias", AC, 32'h1234_5678);
    step(3); chk("jump", 32'(PC), 32'h40);

    wait_leds(4'b0101, 30);
    chk("io_leds_5", 32'(LEDs), 32'h5);
    chk("io_ac_5", AC, 32'h5);
    switches = 4'b1010;
    wait_leds(4'b1010, 30);
    chk("io_leds_a", 32'(LEDs), 32'hA);
    chk("io_ac_a", AC, 32'hA);
    switches = 4'b1111;
    wait_pc(16'hFFFF, 60);
    chk("pc_ffff", 32'(PC), 32'hFFFF);

    step(1);
    chk("pc_wrap", 32'(PC), 32'h0);
    chk("halt_ir", IR, 32'hF000_0000);
    step(2);
    chk("load_ledaddr", AC, 32'hF000_0000);
    chk("leds_f", 32'(LEDs), 32'hF);
    switches = 4'b0011;
    step(12);
    chk("halt_pc", 32'(PC), 32'h0);
    chk("halt_ac", AC, 32'hF000_0000);
    chk("halt_leds", 32'(LEDs), 32'hF);

    reset = 1'b1;
    step(3);
    chk("rst2_pc", 32'(PC), 32'h0);
    chk("rst2_ac", AC, 32'h0);
    chk("rst2_leds", 32'(LEDs), 32'h0);
    reset = 1'b0;

    // Reset lands on the EXECUTE edge of the LED store at 0x27
    step(44);
    chk("pre_abort_ac", AC, 32'h6);
    reset = 1'b1;
    step(1);
    chk("abort_leds", 32'(LEDs), 32'h0);
    chk("abort_pc", 32'(PC), 32'h0);
    step(2);
    reset = 1'b0;
    step(3);
    chk("rerun_ac", AC, 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
